data_fetch_unit: RTL

DATA_FETCH_UNIT -- requirements
Module: data_fetch_unit

---
 rtl/data_fetch_unit.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/data_fetch_unit.sv
// data_fetch_unit: 16x128 row buffer feeding four PE lanes.
// Burst loads to DATAIN, masked burst stores from DATAOUT, host port.
module data_fetch_unit (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              ADDR_START,
    input  logic              ADDR_RST,
    input  logic [3:0]        ADDRESS,
    input  logic [1:0]        BURST_LEN,
    input  logic [1:0]        PE_SEL,
    input  logic              PE_SEL_2x2,
    input  logic              PE_SEL_4,
    input  logic              WRADDR_START,
    input  logic [3:0][31:0]  DATAOUT,
    output logic [3:0][31:0]  DATAIN,
    output logic              DATA_VALID,
    output logic              FETCH_DONE,
    output logic              STORE_DONE,
    input  logic              MEM_WE,
    input  logic [3:0]        MEM_WADDR,
    input  logic [127:0]      MEM_WDATA,
    input  logic [3:0]        MEM_RADDR,
    output logic [127:0]      MEM_RDATA
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LDONE,
        S_STORE,
        S_SDONE
    } state_t;

    state_t state;

    logic [3:0][31:0] mem [16];

    logic [3:0]  base_q;
    logic [1:0]  len_q;
    logic [1:0]  pe_sel_q;
    logic        pe_sel_2x2_q;
    logic        pe_sel_4_q;
    logic [1:0]  cnt;

    logic [3:0]        row;
    logic [3:0]        lane_mask;
    logic [3:0][31:0]  lane_bits;
    logic [3:0][31:0]  row_data;
    logic [3:0][31:0]  row_masked;
    logic [3:0][31:0]  row_merged;

    logic              start_any;
    logic              store_we;
    logic              host_we;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [3:0][31:0]  wr_data;

    // Current row wraps modulo 16 because the adder is 4 bits wide.
    assign row = base_q + {2'b00, cnt};

    // Lane mask from the latched selects; wider groupings take priority.
    always_comb begin
        lane_mask = 4'b0000;
        if (pe_sel_4_q) begin
            lane_mask = 4'b1111;
        end else if (pe_sel_2x2_q) begin
            unique case (pe_sel_q)
                2'b00:   lane_mask = 4'b0011;
                2'b01:   lane_mask = 4'b1100;
                2'b10:   lane_mask = 4'b0101;
                default: lane_mask = 4'b1010;
            endcase
        end else begin
            lane_mask = 4'b0001 << pe_sel_q;
        end
    end

    // Expand the lane mask to a bit mask and form read / merged rows.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            lane_bits[i] = {32{lane_mask[i]}};
        end
        row_data   = mem[row];
        row_masked = row_data & lane_bits;
        row_merged = (row_data & ~lane_bits) | (DATAOUT & lane_bits);
    end

    assign start_any = ADDR_START | WRADDR_START;
    assign store_we  = (state == S_STORE) & ~ADDR_RST;
    assign host_we   = MEM_WE & (state == S_IDLE) & ~start_any;

    // Single write port: PE store when storing, otherwise the host.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = MEM_WADDR;
        wr_data = MEM_WDATA;
        if (store_we) begin
            wr_en   = 1'b1;
            wr_addr = row;
            wr_data = row_merged;
        end else if (host_we) begin
            wr_en   = 1'b1;
        end
    end

    assign MEM_RDATA = mem[MEM_RADDR];

    // Row storage; cleared by reset, abort leaves contents intact.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int r = 0; r < 16; r++) begin
                mem[r] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Request sequencing, row counter and registered PE-side outputs.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state        <= S_IDLE;
            cnt          <= 2'd0;
            base_q       <= 4'd0;
            len_q        <= 2'd0;
            pe_sel_q     <= 2'd0;
            pe_sel_2x2_q <= 1'b0;
            pe_sel_4_q   <= 1'b0;
            DATAIN       <= '0;
            DATA_VALID   <= 1'b0;
            FETCH_DONE   <= 1'b0;
            STORE_DONE   <= 1'b0;
        end else if (ADDR_RST) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            DATAIN     <= '0;
            DATA_VALID <= 1'b0;
            FETCH_DONE <= 1'b0;
            STORE_DONE <= 1'b0;
        end else begin
            FETCH_DONE <= 1'b0;
            STORE_DONE <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    DATAIN     <= '0;
                    DATA_VALID <= 1'b0;
                    if (start_any) begin
                        base_q       <= ADDRESS;
                        len_q        <= BURST_LEN;
                        pe_sel_q     <= PE_SEL;
                        pe_sel_2x2_q <= PE_SEL_2x2;
                        pe_sel_4_q   <= PE_SEL_4;
                        cnt          <= 2'd0;
                        state        <= WRADDR_START ? S_STORE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    DATAIN     <= row_masked;
                    DATA_VALID <= 1'b1;
                    cnt        <= cnt + 2'd1;
                    if (cnt == len_q) begin
                        state <= S_LDONE;
                    end
                end
                S_LDONE: begin
                    DATAIN     <= '0;
                    DATA_VALID <= 1'b0;
                    FETCH_DONE <= 1'b1;
                    cnt        <= 2'd0;
                    state      <= S_IDLE;
                end
                S_STORE: begin
                    cnt <= cnt + 2'd1;
                    if (cnt == len_q) begin
                        state <= S_SDONE;
                    end
                end
                S_SDONE: begin
                    STORE_DONE <= 1'b1;
                    cnt        <= 2'd0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
